// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/ack handshake between fetch and imem
interface fetch_ctrl_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  modport master (output ImemReq, ImemAddr, input ImemAck, ImemRdata);
  modport slave (input ImemReq, ImemAddr, output ImemAck, ImemRdata);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and fetch sequencer against a handshaked imem.
// Define FETCH_EXC_EN to add the ExcReq redirect to EXC_VECTOR (highest priority).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HazardStall,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  input  logic        JumpD,
  input  logic [31:0] JumpTargetD,
`ifdef FETCH_EXC_EN
  input  logic        ExcReq,
`endif
  fetch_ctrl_if.master imem,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic        FlushD
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state, next_state;
  logic [31:0] pc, pend_tgt, tgt_now, redir_tgt;
  logic pend, exc, in_fetch, redir_now, take_redir, deliver;
`ifdef FETCH_EXC_EN
  assign exc = ExcReq;
`else
  assign exc = 1'b0;
`endif
  assign in_fetch  = state == FETCH;
  assign redir_now = exc | BranchTakenD | JumpD;
  assign tgt_now   = (exc ? EXC_VECTOR : BranchTakenD ? BranchTargetD : JumpTargetD) & ~32'h3;
  // a redirect arriving with the ack supersedes any older pending target
  assign redir_tgt  = redir_now ? tgt_now : pend_tgt;
  assign take_redir = in_fetch ? imem.ImemAck & (pend | redir_now) : redir_now;
  assign deliver    = ~take_redir & ~HazardStall & (~in_fetch | imem.ImemAck);
  assign PCF      = pc;
  assign PCPlus4F = pc + 32'd4;
  assign FlushD   = redir_now;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= FETCH;
    else state <= next_state;
  always_comb
    next_state = in_fetch ? ((imem.ImemAck & ~take_redir & HazardStall) ? HOLD : FETCH)
                          : ((take_redir | ~HazardStall) ? FETCH : HOLD);
  always_comb begin
    imem.ImemReq  = in_fetch & ~RST;
    imem.ImemAddr = pc;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pc          <= RESET_PC;
      pend        <= 1'b0;
      pend_tgt    <= '0;
      InstrF      <= '0;
      InstrValidF <= 1'b0;
    end else begin
      pc          <= take_redir ? redir_tgt : deliver ? pc + 32'd4 : pc;
      pend        <= in_fetch & ~imem.ImemAck & (pend | redir_now);
      InstrValidF <= deliver;
      if (in_fetch & ~imem.ImemAck & redir_now) pend_tgt <= tgt_now;
      if (in_fetch & imem.ImemAck & ~take_redir) InstrF <= imem.ImemRdata;
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench with an imem model, redirect vector table and scoreboard
module tb_fetch_ctrl;
  logic CLK = 0, RST = 0, HazardStall = 0, BranchTakenD = 0, JumpD = 0;
  logic [31:0] BranchTargetD = 0, JumpTargetD = 0;
`ifdef FETCH_EXC_EN
  logic ExcReq = 0;
`endif
  logic [31:0] PCF, PCPlus4F, InstrF;
  logic InstrValidF, FlushD;
  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_PC(32'h0000_0040), .EXC_VECTOR(32'h8000_0180)) dut (
    .CLK(CLK), .RST(RST), .HazardStall(HazardStall),
    .BranchTakenD(BranchTakenD), .BranchTargetD(BranchTargetD),
    .JumpD(JumpD), .JumpTargetD(JumpTargetD),
`ifdef FETCH_EXC_EN
    .ExcReq(ExcReq),
`endif
    .imem(bus), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
    .InstrValidF(InstrValidF), .FlushD(FlushD));
  always #5 CLK = ~CLK;

  typedef struct {
    int bc; logic [31:0] bt;
    int jc; logic [31:0] jt;
    int ec;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] sb[$];
  int checks = 0, failures = 0;
  int mem_wait = 0, cnt = 0;
  bit mem_on = 0;

  function automatic logic [31:0] wf(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_redir();
    BranchTakenD = 0; JumpD = 0;
`ifdef FETCH_EXC_EN
    ExcReq = 0;
`endif
  endtask

  task automatic drive(input int c, input vec_t v);
    BranchTakenD = v.bc == c; BranchTargetD = v.bt;
    JumpD = v.jc == c; JumpTargetD = v.jt;
`ifdef FETCH_EXC_EN
    ExcReq = v.ec == c;
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1; clear_redir(); HazardStall = 0;
    @(negedge CLK); RST = 0;
  endtask

  // memory model: acks after mem_wait idle request cycles, inputs settle at posedge+2
  initial begin
    bus.ImemAck = 0; bus.ImemRdata = 0;
    forever begin
      @(posedge CLK); #2;
      if (RST || !mem_on || !bus.ImemReq) begin
        bus.ImemAck = 0; cnt = 0;
      end else if (cnt >= mem_wait) begin
        bus.ImemAck = 1; bus.ImemRdata = wf(bus.ImemAddr); cnt = 0;
      end else begin
        bus.ImemAck = 0; cnt++;
      end
    end
  end

  // scoreboard consumer: every delivered instruction must match the oldest expected word
  initial forever begin
    @(posedge CLK); #1;
    if (InstrValidF) begin
      if (sb.size() == 0) chk("unexpected_valid", InstrF, 32'hxxxx_xxxx);
      else chk("instr", InstrF, sb.pop_front());
    end
  end

  initial begin
    vec_t v;
    vecs.push_back('{1, 32'h0000_0203, 0, 32'h0, 0, 32'h0000_0200});
    vecs.push_back('{0, 32'h0, 2, 32'h0000_0307, 0, 32'h0000_0304});
    vecs.push_back('{3, 32'h0000_0400, 3, 32'h0000_0500, 0, 32'h0000_0400});
    vecs.push_back('{1, 32'h0000_0600, 2, 32'h0000_0704, 0, 32'h0000_0704});
    vecs.push_back('{0, 32'h0, 0, 32'h0, 0, 32'h0000_0044});
    vecs.push_back('{0, 32'h0, 3, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC});
`ifdef FETCH_EXC_EN
    vecs.push_back('{1, 32'h0000_0203, 1, 32'h0000_0307, 1, 32'h8000_0180});
`endif
    // reset state, then zero-wait streaming
    mem_wait = 0; mem_on = 1;
    @(negedge CLK); RST = 1; #1;
    chk("rst_req", bus.ImemReq, 0);
    chk("rst_pc", PCF, 32'h40);
    chk("rst_instr", InstrF, 0);
    chk("rst_valid", InstrValidF, 0);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) sb.push_back(wf(32'h40 + 4 * i));
    RST = 0; #1;
    chk("rel_req", bus.ImemReq, 1);
    chk("rel_addr", bus.ImemAddr, 32'h40);
    @(posedge CLK);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("zw_pc", PCF, 32'h44 + 4 * k);
      chk("zw_valid", InstrValidF, 1);
    end
    mem_on = 0;
    tick(); tick();
    chk("zw_sb_empty", sb.size(), 0);
    // two wait states per fetch
    mem_wait = 2; mem_on = 1;
    for (int i = 0; i < 3; i++) sb.push_back(wf(32'h40 + 4 * i));
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("ws_addr", bus.ImemAddr, 32'h40 + 4 * ((k - 1) / 3));
      chk("ws_valid", InstrValidF, (k > 1 && k % 3 == 1));
    end
    mem_on = 0;
    tick(); tick();
    chk("ws_sb_empty", sb.size(), 0);
    // hazard stall at 0x100
    mem_wait = 0; mem_on = 1;
    do_reset();
    @(posedge CLK); #3; JumpD = 1; JumpTargetD = 32'h100;
    tick(); JumpD = 0; HazardStall = 1;
    chk("hz_addr", bus.ImemAddr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hz_req", bus.ImemReq, 0);
      chk("hz_instr", InstrF, wf(32'h100));
      chk("hz_pc", PCF, 32'h100);
    end
    sb.push_back(wf(32'h100)); HazardStall = 0;
    tick(); mem_on = 0;
    chk("hz_next_addr", bus.ImemAddr, 32'h104);
    chk("hz_next_req", bus.ImemReq, 1);
    tick(); tick();
    chk("hz_sb_empty", sb.size(), 0);
    // PC wraps at the top of the address space
    mem_wait = 0; mem_on = 1;
    do_reset();
    @(posedge CLK); #3; JumpD = 1; JumpTargetD = 32'hFFFF_FFFC;
    tick(); JumpD = 0;
    chk("wrap_plus4", PCPlus4F, 32'h0);
    sb.push_back(wf(32'hFFFF_FFFC));
    tick(); mem_on = 0;
    chk("wrap_addr", bus.ImemAddr, 32'h0);
    tick(); tick();
    chk("wrap_sb_empty", sb.size(), 0);
    // reset asserted while a request waits
    mem_wait = 0; mem_on = 1;
    sb.push_back(wf(32'h40)); sb.push_back(wf(32'h44));
    do_reset();
    @(posedge CLK);
    tick(); #2; mem_wait = 2;
    tick(); #2;
    chk("mr_pre_addr", bus.ImemAddr, 32'h48);
    RST = 1; #1;
    chk("mr_req", bus.ImemReq, 0);
    chk("mr_pc", PCF, 32'h40);
    chk("mr_instr", InstrF, 0);
    @(negedge CLK); RST = 0; #1;
    chk("mr_rel_req", bus.ImemReq, 1);
    chk("mr_rel_addr", bus.ImemAddr, 32'h40);
    mem_on = 0;
    tick(); tick();
    chk("mr_sb_empty", sb.size(), 0);
    // redirect vector table against a two-wait fetch at 0x40
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      mem_wait = 2; mem_on = 1;
      if (v.bc == 0 && v.jc == 0 && v.ec == 0) sb.push_back(wf(32'h40));
      do_reset();
      for (int c = 1; c <= 4; c++) begin
        tick(); clear_redir();
        if (c < 4) chk("rd_hold_addr", bus.ImemAddr, 32'h40);
        else begin
          chk("rd_next_addr", bus.ImemAddr, v.exp);
          mem_on = 0;
        end
        #2;
        if (c < 4) begin
          drive(c, v); #1;
          chk("rd_flush", FlushD, (v.bc == c) || (v.jc == c) || (v.ec == c));
        end
      end
      tick(); tick();
      chk("rd_sb_empty", sb.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller that owns the program counter and sequences instruction fetch against a handshaked instruction memory. It chooses the next PC from sequential, branch, jump and (optionally) exception sources. It tolerates memory wait states and downstream hazard stalls, and delivers one valid instruction per accepted fetch to the IF/ID register. It sits between the hazard unit and decode control on one side and instruction memory on the other.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h8000_0180, exception redirect target (used only with FETCH_EXC_EN)
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- HazardStall  in  1  downstream cannot accept an instruction this cycle
- BranchTakenD  in  1  branch redirect request
- BranchTargetD  in  32  branch target
- JumpD  in  1  jump redirect request
- JumpTargetD  in  32  jump target
- ExcReq  in  1  exception redirect request (present only with FETCH_EXC_EN)
- ImemReq  out  1  fetch request
- ImemAddr  out  32  fetch address (= PCF)
- ImemAck  in  1  read data valid; completes the request
- ImemRdata  in  32  instruction word
- PCF  out  32  current fetch PC
- PCPlus4F  out  32  PCF + 4, combinational
- InstrF  out  32  registered instruction for IF/ID
- InstrValidF  out  1  one-cycle pulse per delivered instruction
- FlushD  out  1  combinational; high in any cycle a redirect input is high

## Operation
- States:
  - FETCH: ImemReq = 1.
  - HOLD: instruction captured, waiting for HazardStall to drop; ImemReq = 0.
- Reset values: state FETCH, PCF = RESET_PC, InstrF = 0, InstrValidF = 0, redirect-pending flag = 0, ImemReq = 0 while RST is high.
- Redirect priority within a cycle: ExcReq > BranchTakenD > JumpD.
  - Targets have bits [1:0] forced to 0.
- FETCH, no ack, redirect seen:
  - Latch the target and set pending.
  - PCF/ImemAddr stay unchanged until ack.
  - A later redirect before the ack overwrites the pending target.
- FETCH with ImemAck, in priority order:
  - Redirect pending or redirect this cycle: discard data, PCF <= target, clear pending, InstrValidF <= 0, stay FETCH.
  - Else HazardStall = 0: InstrF <= ImemRdata, InstrValidF <= 1, PCF <= PCF + 4, stay FETCH.
  - Else: InstrF <= ImemRdata, InstrValidF <= 0, go HOLD.
- HOLD:
  - Redirect: drop held instruction, PCF <= target, go FETCH.
  - Else HazardStall = 0: InstrValidF <= 1, PCF <= PCF + 4, go FETCH.
  - Else: remain in HOLD, InstrF held.
- Arithmetic: PC + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- ImemAck outside FETCH is ignored.

## Timing
- Zero-wait memory: one instruction per cycle.
  - Acked on cycle N, InstrValidF high on N+1 with that word.
  - Next request issues on N+1 at PCF + 4.
- Each memory wait cycle adds one cycle of latency; ImemReq/ImemAddr remain stable until ack.
- Redirect to first request at target:
  - Next cycle when the ack arrives in the same cycle or in HOLD.
  - Otherwise the cycle after the outstanding ack.
- FlushD is combinational with redirect inputs: zero latency.
- RST asserted mid-request: ImemReq drops immediately and all state returns to reset values; any later ack for the old request is the memory's responsibility to cancel.

## Configuration
- FETCH_EXC_EN defined:
  - ExcReq port exists, highest redirect priority, target EXC_VECTOR.
- Undefined:
  - No ExcReq port; EXC_VECTOR unused.
  - Redirect logic considers branch and jump only.

## Test plan
- Reset with RESET_PC=32'h0000_0040: release RST -> ImemReq=1, ImemAddr=0x40; zero-wait acks with words W0..W3 -> InstrValidF pulses 4 consecutive cycles with W0..W3, PCF steps 0x44, 0x48, 0x4C, 0x50.
- Two wait cycles per fetch -> ImemAddr stable 3 cycles per request, InstrValidF one pulse every 3 cycles.
- HazardStall high 3 cycles when ack arrives at 0x100 -> state HOLD, ImemReq=0, InstrF holds word; stall drop -> one InstrValidF pulse, next ImemAddr=0x104.
- BranchTakenD with target 0x203 during a wait at 0x100 -> FlushD=1 that cycle; ImemAddr stays 0x100 until ack; data discarded with no InstrValidF; next ImemAddr=0x200.
- With FETCH_EXC_EN: ExcReq, BranchTakenD and JumpD in the same cycle -> next ImemAddr=0x8000_0180.
- PCF=0xFFFF_FFFC acked with no stall -> next ImemAddr=0x0000_0000.
- Reset pulse during a wait -> ImemReq drops immediately; next request after release at RESET_PC.
